// File: rtl/irq_arbiter.sv
// Interrupt arbiter: synchronizes/edge-detects request lines, holds them pending and presents the top-priority preemptor.
// Source-to-request latency 3 clocks; take/eret act on the next edge and reach outputs only through registered state.
module irq_arbiter #(
  parameter int NIRQ     = 3,
  parameter int NBIT_IRQ = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NIRQ-1:0]     irq_src,
  input  logic                irq_gen,
  input  logic [NIRQ-1:0]     irq_mask,
  input  logic                irq_take,
  input  logic                irq_eret,
  output logic                irq_req,
  output logic [NBIT_IRQ-1:0] irq_num,
  output logic                irq_busy
);

  logic [NIRQ-1:0]     s1_q, s2_q, s3_q;
  logic [NIRQ-1:0]     pend_q, pend_d;
  logic [NIRQ-1:0]     isv_q, isv_d;
  logic [NIRQ-1:0]     cand;
  logic [NIRQ-1:0]     take_oh;
  logic                win_vld, isv_vld, req_c;
  logic [NBIT_IRQ-1:0] win_idx, isv_idx;

  // Descending scan so the lowest index (highest priority) is the one left standing.
  always_comb begin
    cand    = pend_q & irq_mask;
    win_vld = 1'b0;
    win_idx = '0;
    isv_vld = 1'b0;
    isv_idx = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_vld = 1'b1;
        win_idx = NBIT_IRQ'(i);
      end
      if (isv_q[i]) begin
        isv_vld = 1'b1;
        isv_idx = NBIT_IRQ'(i);
      end
    end
    req_c = ~rst & irq_gen & win_vld & (~isv_vld | (win_idx < isv_idx));
  end

  always_comb begin
    take_oh = '0;
    for (int i = 0; i < NIRQ; i++) begin
      take_oh[i] = irq_take & req_c & (win_idx == NBIT_IRQ'(i));
    end
    // A fresh edge on the line being taken re-sets its pending bit.
    pend_d = (pend_q & ~take_oh) | (s2_q & ~s3_q);
    // x & (x-1) drops the lowest set bit: the innermost nesting level returns first.
    isv_d  = (irq_eret ? (isv_q & (isv_q - NIRQ'(1))) : isv_q) | take_oh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      pend_q <= '0;
      isv_q  <= '0;
    end else begin
      s1_q   <= irq_src;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      pend_q <= pend_d;
      isv_q  <= isv_d;
    end
  end

  assign irq_req  = req_c;
  assign irq_num  = req_c ? win_idx : '0;
  assign irq_busy = ~rst & (|isv_q);

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: drives at negedge, checks at negedge against hand-computed values.
module tb_irq_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] irq_src;
  logic       irq_gen;
  logic [2:0] irq_mask;
  logic       irq_take;
  logic       irq_eret;
  logic       irq_req;
  logic [1:0] irq_num;
  logic       irq_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  irq_arbiter #(.NIRQ(3), .NBIT_IRQ(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_src  (irq_src),
    .irq_gen  (irq_gen),
    .irq_mask (irq_mask),
    .irq_take (irq_take),
    .irq_eret (irq_eret),
    .irq_req  (irq_req),
    .irq_num  (irq_num),
    .irq_busy (irq_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [1:0] num, input logic busy);
    chk({tag, ".req"},  32'(irq_req),  32'(req));
    chk({tag, ".num"},  32'(irq_num),  32'(num));
    chk({tag, ".busy"}, 32'(irq_busy), 32'(busy));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic take_pulse();
    irq_take = 1'b1;
    tick(1);
    irq_take = 1'b0;
  endtask

  task automatic eret_pulse();
    irq_eret = 1'b1;
    tick(1);
    irq_eret = 1'b0;
  endtask

  // Raise lines for two cycles; pending bits land on the third edge.
  task automatic edge_req(input logic [2:0] lines);
    irq_src = lines;
    tick(2);
    irq_src = 3'b000;
    tick(1);
  endtask

  initial begin
    rst      = 1'b1;
    irq_src  = 3'b000;
    irq_gen  = 1'b1;
    irq_mask = 3'b111;
    irq_take = 1'b0;
    irq_eret = 1'b0;
    tick(3);
    chk_out("reset", 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    tick(2);

    // Single request on line 1, latency check
    irq_src = 3'b010;
    tick(1);
    chk("lat.e0", 32'(irq_req), 32'd0);
    tick(1);
    chk("lat.e1", 32'(irq_req), 32'd0);
    irq_src = 3'b000;
    tick(1);
    chk_out("single.req", 1'b1, 2'd1, 1'b0);
    take_pulse();
    chk_out("single.take", 1'b0, 2'd0, 1'b1);
    eret_pulse();
    chk_out("single.eret", 1'b0, 2'd0, 1'b0);
    tick(3);

    // Priority and nesting
    edge_req(3'b110);
    chk_out("prio.12", 1'b1, 2'd1, 1'b0);
    take_pulse();
    chk_out("prio.take1", 1'b0, 2'd0, 1'b1);
    edge_req(3'b001);
    chk_out("nest.req0", 1'b1, 2'd0, 1'b1);
    take_pulse();
    chk_out("nest.take0", 1'b0, 2'd0, 1'b1);
    eret_pulse();
    chk_out("nest.eret0", 1'b0, 2'd0, 1'b1);
    eret_pulse();
    chk_out("nest.eret1", 1'b1, 2'd2, 1'b0);

    // Masking and gating with line 2 pending
    irq_mask = 3'b011;
    #1 chk_out("mask.off", 1'b0, 2'd0, 1'b0);
    irq_mask = 3'b111;
    #1 chk_out("mask.on", 1'b1, 2'd2, 1'b0);
    irq_gen = 1'b0;
    #1 chk_out("gen.off", 1'b0, 2'd0, 1'b0);
    tick(3);
    irq_gen = 1'b1;
    #1 chk_out("gen.retain", 1'b1, 2'd2, 1'b0);
    tick(1);
    take_pulse();
    chk_out("mask.take2", 1'b0, 2'd0, 1'b1);
    eret_pulse();
    chk_out("mask.eret2", 1'b0, 2'd0, 1'b0);

    // New edge on line 1 coincident with take of line 1
    edge_req(3'b010);
    tick(3);
    chk_out("coll.req", 1'b1, 2'd1, 1'b0);
    irq_src = 3'b010;
    tick(2);
    take_pulse();
    irq_src = 3'b000;
    chk_out("coll.take", 1'b0, 2'd0, 1'b1);
    eret_pulse();
    chk_out("coll.eret", 1'b1, 2'd1, 1'b0);
    take_pulse();
    eret_pulse();
    chk_out("coll.clean", 1'b0, 2'd0, 1'b0);

    // Spurious handshakes
    take_pulse();
    chk_out("spur.take", 1'b0, 2'd0, 1'b0);
    eret_pulse();
    chk_out("spur.eret", 1'b0, 2'd0, 1'b0);
    tick(2);
    chk_out("spur.after", 1'b0, 2'd0, 1'b0);

    // Reset mid-ISR with isv=010, pend=100; line 0 held high across reset
    edge_req(3'b110);
    take_pulse();
    chk_out("rst.pre", 1'b0, 2'd0, 1'b1);
    irq_src = 3'b001;
    rst     = 1'b1;
    tick(1);
    chk_out("rst.mid", 1'b0, 2'd0, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(2);
    chk_out("rst.lat", 1'b0, 2'd0, 1'b0);
    tick(1);
    chk_out("rst.held", 1'b1, 2'd0, 1'b0);
    take_pulse();
    eret_pulse();
    tick(4);
    chk_out("rst.once", 1'b0, 2'd0, 1'b0);
    irq_src = 3'b000;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
